// File: rtl/gcd_bus_master.sv
// Initiator for the GCD peripheral bus: writes both operands, triggers start, polls
// status until done and returns the result on a valid/ready response port.
module gcd_bus_master #(
    parameter int STROBE_CYC = 1,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_POLLS  = 256
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_w,
    output logic [1:0]  rsp_err,
    output logic        busy,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);
    // state       | meaning
    // IDLE        | waiting for a command, cmd_ready high
    // CHECK       | reject zero operands before touching the bus
    // WR_A1/WR_A2 | write operand A / operand B
    // RD_START    | read A2 to start the peripheral, data discarded
    // SETTLE      | idle cycles before the first status poll
    // POLL_S      | read status, bit3 high means still busy
    // POLL_GAP    | one idle cycle between polls
    // RD_W        | read the result
    // RESP        | result held until accepted
    localparam logic [15:0] ADDR_A1 = 16'h00F8;
    localparam logic [15:0] ADDR_A2 = 16'h00FC;
    localparam logic [15:0] ADDR_W  = 16'h0100;
    localparam logic [15:0] ADDR_S  = 16'h0104;
    localparam logic [1:0]  ERR_OK   = 2'b00;
    localparam logic [1:0]  ERR_ZERO = 2'b01;
    localparam logic [1:0]  ERR_TMO  = 2'b10;
    localparam int CNT_W  = 16;
    localparam int POLL_W = $clog2(MAX_POLLS + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_CHECK, ST_WR_A1, ST_WR_A2, ST_RD_START,
        ST_SETTLE, ST_POLL_S, ST_POLL_GAP, ST_RD_W, ST_RESP
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

    state_t            state;
    phase_t            phase;
    logic [CNT_W-1:0]  cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic [POLL_W-1:0] poll_nxt;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic              is_rd;

    assign is_rd    = (state == ST_RD_START) || (state == ST_POLL_S) || (state == ST_RD_W);
    assign poll_nxt = poll_cnt + 1'b1;

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            state     <= ST_IDLE;
            phase     <= PH_SETUP;
            cnt       <= '0;
            poll_cnt  <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_w     <= '0;
            rsp_err   <= ERR_OK;
            busy      <= 1'b0;
            saddress  <= '0;
            srd       <= 1'b0;
            swr       <= 1'b0;
            sdata_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_a      <= cmd_a;
                        op_b      <= cmd_b;
                        poll_cnt  <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // The peripheral never terminates on a zero operand, so refuse it here.
                    if (op_a == '0 || op_b == '0) begin
                        rsp_w     <= '0;
                        rsp_err   <= ERR_ZERO;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        saddress  <= ADDR_A1;
                        sdata_out <= op_a;
                        phase     <= PH_SETUP;
                        state     <= ST_WR_A1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        saddress <= ADDR_S;
                        phase    <= PH_SETUP;
                        state    <= ST_POLL_S;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_POLL_GAP: begin
                    phase <= PH_SETUP;
                    state <= ST_POLL_S;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    case (phase)
                        PH_SETUP: begin
                            srd   <= is_rd;
                            swr   <= !is_rd;
                            cnt   <= CNT_W'(STROBE_CYC - 1);
                            phase <= PH_STROBE;
                        end
                        PH_STROBE: begin
                            if (cnt == '0) begin
                                srd   <= 1'b0;
                                swr   <= 1'b0;
                                phase <= PH_HOLD;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                        default: begin
                            // End of HOLD: sdata_in is sampled on this edge.
                            phase <= PH_SETUP;
                            case (state)
                                ST_WR_A1: begin
                                    saddress  <= ADDR_A2;
                                    sdata_out <= op_b;
                                    state     <= ST_WR_A2;
                                end
                                ST_WR_A2: begin
                                    saddress <= ADDR_A2;
                                    state    <= ST_RD_START;
                                end
                                ST_RD_START: begin
                                    cnt   <= CNT_W'(SETTLE_CYC - 1);
                                    state <= ST_SETTLE;
                                end
                                ST_POLL_S: begin
                                    if (!sdata_in[3]) begin
                                        saddress <= ADDR_W;
                                        state    <= ST_RD_W;
                                    end else if (poll_nxt == POLL_W'(MAX_POLLS)) begin
                                        poll_cnt  <= poll_nxt;
                                        rsp_w     <= '0;
                                        rsp_err   <= ERR_TMO;
                                        rsp_valid <= 1'b1;
                                        state     <= ST_RESP;
                                    end else begin
                                        poll_cnt <= poll_nxt;
                                        state    <= ST_POLL_GAP;
                                    end
                                end
                                ST_RD_W: begin
                                    rsp_w     <= sdata_in;
                                    rsp_err   <= ERR_OK;
                                    rsp_valid <= 1'b1;
                                    state     <= ST_RESP;
                                end
                                default: state <= ST_IDLE;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_bus_master.sv
// Directed bench for gcd_bus_master against a behavioural GCD peripheral model.
module tb_gcd_bus_master;
    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_w;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gcd_bus_master #(.STROBE_CYC(1), .SETTLE_CYC(2), .MAX_POLLS(4)) u_dut (
        .clk(clk), .n_reset(n_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_w(rsp_w), .rsp_err(rsp_err),
        .busy(busy), .saddress(saddress), .srd(srd), .swr(swr),
        .sdata_out(sdata_out), .sdata_in(sdata_in)
    );

    // Peripheral model: registers sampled on strobe rising edges, status busy for busy_cyc clocks.
    int          busy_cyc = 3;
    logic        stuck_s  = 1'b0;
    logic [31:0] m_a1 = '0, m_a2 = '0, m_w = '0;
    int          m_busy = 0;
    logic        srd_q = 1'b0, swr_q = 1'b0;
    int          n_rd = 0, n_wr = 0, n_rd_fc = 0, n_rd_s = 0, n_rd_w = 0;
    logic [31:0] last_f8 = '0, last_fc = '0;
    int          both_cnt = 0;

    function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        srd_q <= srd;
        swr_q <= swr;
        if (m_busy > 0) m_busy <= m_busy - 1;
        if (swr && !swr_q) begin
            n_wr <= n_wr + 1;
            if (saddress == 16'h00F8) begin
                m_a1 <= sdata_out;
                last_f8 <= sdata_out;
            end else if (saddress == 16'h00FC) begin
                m_a2 <= sdata_out;
                last_fc <= sdata_out;
            end
        end
        if (srd && !srd_q) begin
            n_rd <= n_rd + 1;
            case (saddress)
                16'h00FC: begin
                    n_rd_fc <= n_rd_fc + 1;
                    m_busy  <= busy_cyc;
                    m_w     <= gcd(m_a1, m_a2);
                end
                16'h0104: n_rd_s <= n_rd_s + 1;
                16'h0100: n_rd_w <= n_rd_w + 1;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (saddress)
            16'h00F8: sdata_in = m_a1;
            16'h00FC: sdata_in = m_a2;
            16'h0100: sdata_in = m_w;
            16'h0104: sdata_in = {28'h0, (m_busy != 0) || stuck_s, 3'b111};
            default:  sdata_in = 32'hDEAD_BEEF;
        endcase
    end

    always @(negedge clk or posedge srd or posedge swr)
        if (srd && swr) both_cnt <= both_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready_wait", {31'b0, cmd_ready}, 1);
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rsp_arrived", {31'b0, rsp_valid}, 1);
    endtask

    task automatic take_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'b0, rsp_valid}, 0);
        check("cmd_ready_after", {31'b0, cmd_ready}, 1);
        check("busy_after", {31'b0, busy}, 0);
    endtask

    initial begin
        int lat, t, b_s, b_w, b_fc, b_rw;
        n_reset   = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_saddress", {16'b0, saddress}, 0);
        check("rst_strobes", {30'b0, srd, swr}, 0);
        check("rst_sdata_out", sdata_out, 0);
        check("rst_rsp", {rsp_w[29:0], rsp_err}, 0);
        @(negedge clk) n_reset = 1'b0;

        // 48,18 with a slow peripheral: three status polls.
        busy_cyc = 12;
        b_s = n_rd_s; b_w = n_rd_w; b_fc = n_rd_fc;
        send(48, 18);
        wait_rsp(lat);
        check("g48_w", rsp_w, 6);
        check("g48_err", {30'b0, rsp_err}, 0);
        check("g48_wr_f8", last_f8, 48);
        check("g48_wr_fc", last_fc, 18);
        check("g48_start_reads", n_rd_fc - b_fc, 1);
        check("g48_polls", n_rd_s - b_s, 3);
        check("g48_w_reads", n_rd_w - b_w, 1);
        take_rsp();

        // 7,7 done within settle: minimum latency, one poll, then hold rsp_ready low.
        busy_cyc = 3;
        b_s = n_rd_s;
        send(7, 7);
        wait_rsp(lat);
        check("g7_latency", lat, 18);
        check("g7_w", rsp_w, 7);
        check("g7_err", {30'b0, rsp_err}, 0);
        check("g7_polls", n_rd_s - b_s, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'b0, rsp_valid}, 1);
            check("hold_w", rsp_w, 7);
            check("hold_cmd_ready", {31'b0, cmd_ready}, 0);
        end
        take_rsp();

        // Zero operand: fast error, no bus traffic.
        b_rw = n_rd + n_wr;
        send(0, 5);
        wait_rsp(lat);
        check("zero_fast", {31'b0, lat <= 3}, 1);
        check("zero_err", {30'b0, rsp_err}, 1);
        check("zero_w", rsp_w, 0);
        check("zero_no_bus", n_rd + n_wr - b_rw, 0);
        take_rsp();

        // Status stuck busy: timeout after MAX_POLLS reads, no result read.
        stuck_s = 1'b1;
        b_s = n_rd_s; b_w = n_rd_w;
        send(48, 18);
        wait_rsp(lat);
        check("tmo_err", {30'b0, rsp_err}, 2);
        check("tmo_w", rsp_w, 0);
        check("tmo_polls", n_rd_s - b_s, 4);
        check("tmo_no_w_read", n_rd_w - b_w, 0);
        take_rsp();

        // Async reset while a status read strobe is high.
        send(9, 6);
        t = 0;
        while (!(srd && saddress == 16'h0104) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("poll_strobe_seen", {31'b0, srd}, 1);
        #2 n_reset = 1'b1;
        #1;
        check("arst_strobes", {30'b0, srd, swr}, 0);
        check("arst_saddress", {16'b0, saddress}, 0);
        stuck_s = 1'b0;
        @(negedge clk) n_reset = 1'b0;
        @(posedge clk);
        #1;
        check("arst_cmd_ready", {31'b0, cmd_ready}, 1);
        check("arst_busy", {31'b0, busy}, 0);
        send(21, 14);
        wait_rsp(lat);
        check("g21_w", rsp_w, 7);
        check("g21_err", {30'b0, rsp_err}, 0);
        take_rsp();

        check("strobe_exclusive", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
